// File: rtl/mem_pkg.sv
// Shared types for the memory master: request kinds and FSM states.
package mem_pkg;

  typedef enum logic [1:0] {
    KIND_INSTR = 2'b00,
    KIND_IMM   = 2'b01,
    KIND_READ  = 2'b10,
    KIND_WRITE = 2'b11
  } req_kind_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_ACCESS,
    S_RESP
  } state_e;

endpackage

// File: rtl/mem_master.sv
// Memory master: sequences one request through address, access and
// response phases, reusing the last latched address when it matches.
module mem_master
  import mem_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_reqValid,
  output logic       o_reqReady,
  input  logic [1:0] i_reqKind,
  input  logic [7:0] i_reqAddr,
  input  logic [7:0] i_reqWData,
  output logic       o_rspValid,
  output logic [7:0] o_rspData,
  input  logic       i_rspReady,
  output logic [7:0] o_address,
  output logic       o_addressEn,
  output logic [7:0] o_writeData,
  output logic       o_writeEn,
  output logic       o_readDataSelect,
  output logic       o_immediateSelect,
  output logic       o_outEnable,
  input  logic [7:0] i_readData
);

  state_e    state_q, state_d;
  req_kind_e kind_q, kind_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] shadow_q, shadow_d;
  logic       shadow_vld_q, shadow_vld_d;
  logic [7:0] rsp_q, rsp_d;
  logic       hit;

  assign hit = shadow_vld_q && (i_reqAddr == shadow_q);

  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    shadow_d     = shadow_q;
    shadow_vld_d = shadow_vld_q;
    rsp_d        = rsp_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_reqValid) begin
          kind_d  = req_kind_e'(i_reqKind);
          addr_d  = i_reqAddr;
          wdata_d = i_reqWData;
          state_d = hit ? S_ACCESS : S_ADDR;
        end
      end
      S_ADDR: begin
        shadow_d     = addr_q;
        shadow_vld_d = 1'b1;
        state_d      = S_ACCESS;
      end
      S_ACCESS: begin
        rsp_d   = (kind_q == KIND_WRITE) ? wdata_q : i_readData;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (i_rspReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      kind_q       <= KIND_INSTR;
      addr_q       <= 8'h00;
      wdata_q      <= 8'h00;
      shadow_q     <= 8'h00;
      shadow_vld_q <= 1'b0;
      rsp_q        <= 8'h00;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      shadow_q     <= shadow_d;
      shadow_vld_q <= shadow_vld_d;
      rsp_q        <= rsp_d;
    end
  end

  // Bus strobes decode only registered state, never the request inputs.
  logic in_access;
  logic is_write;

  assign in_access         = (state_q == S_ACCESS);
  assign is_write          = (kind_q == KIND_WRITE);
  assign o_reqReady        = (state_q == S_IDLE);
  assign o_rspValid        = (state_q == S_RESP);
  assign o_rspData         = rsp_q;
  assign o_addressEn       = (state_q == S_ADDR);
  assign o_address         = o_addressEn ? addr_q : shadow_q;
  assign o_writeEn         = in_access && is_write;
  assign o_writeData       = wdata_q;
  assign o_outEnable       = in_access && !is_write;
  assign o_readDataSelect  = in_access && (kind_q != KIND_READ)
                             && !is_write;
  assign o_immediateSelect = in_access && (kind_q == KIND_IMM);

endmodule

// File: tb/tb_mem_master.sv
// Bench for mem_master: transaction-level reference model with a
// per-cycle compare process plus directed literal checks.
module tb_mem_master;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_reqValid = 1'b0;
  logic       o_reqReady;
  logic [1:0] i_reqKind = 2'b00;
  logic [7:0] i_reqAddr = 8'h00;
  logic [7:0] i_reqWData = 8'h00;
  logic       o_rspValid;
  logic [7:0] o_rspData;
  logic       i_rspReady = 1'b0;
  logic [7:0] o_address;
  logic       o_addressEn;
  logic [7:0] o_writeData;
  logic       o_writeEn;
  logic       o_readDataSelect;
  logic       o_immediateSelect;
  logic       o_outEnable;
  logic [7:0] i_readData;

  int checks = 0;
  int errors = 0;
  logic run_chk = 1'b0;

  always #5 clk = ~clk;

  mem_master dut (
    .i_clk(clk),
    .i_reset(i_reset),
    .i_reqValid(i_reqValid),
    .o_reqReady(o_reqReady),
    .i_reqKind(i_reqKind),
    .i_reqAddr(i_reqAddr),
    .i_reqWData(i_reqWData),
    .o_rspValid(o_rspValid),
    .o_rspData(o_rspData),
    .i_rspReady(i_rspReady),
    .o_address(o_address),
    .o_addressEn(o_addressEn),
    .o_writeData(o_writeData),
    .o_writeEn(o_writeEn),
    .o_readDataSelect(o_readDataSelect),
    .o_immediateSelect(o_immediateSelect),
    .o_outEnable(o_outEnable),
    .i_readData(i_readData)
  );

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Memory side: address latch, data RAM and two ROM halves by formula.
  logic [7:0] lat_addr = 8'h00;
  logic [7:0] bus_ram [256];

  function automatic logic [7:0] rom_instr(input logic [7:0] a);
    return ~a;
  endfunction

  function automatic logic [7:0] rom_imm(input logic [7:0] a);
    return a + 8'h1C;
  endfunction

  always @(posedge clk) begin
    if (o_addressEn) lat_addr <= o_address;
    if (o_writeEn) bus_ram[lat_addr] <= o_writeData;
  end

  assign i_readData = !o_outEnable ? 8'h00 :
                      !o_readDataSelect ? bus_ram[lat_addr] :
                      o_immediateSelect ? rom_imm(lat_addr) :
                      rom_instr(lat_addr);

  // Reference model: one transaction in flight, cycle index since accept.
  logic [7:0] ref_ram [256];
  logic       m_busy = 1'b0;
  int         m_cnt = 0;
  int         m_lat = 3;
  logic       m_skip = 1'b0;
  logic [1:0] m_kind = 2'b00;
  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_wd = 8'h00;
  logic [7:0] m_exp = 8'h00;
  logic [7:0] m_sh = 8'h00;
  logic       m_sv = 1'b0;

  function automatic logic [7:0] ref_data(input logic [1:0] k,
                                          input logic [7:0] a,
                                          input logic [7:0] d);
    case (k)
      2'd0:    return rom_instr(a);
      2'd1:    return rom_imm(a);
      2'd2:    return ref_ram[a];
      default: return d;
    endcase
  endfunction

  always @(posedge clk) begin
    if (m_busy && m_cnt == m_lat - 1 && m_kind == 2'd3)
      ref_ram[m_addr] <= m_wd;
    if (i_reset) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_sv   <= 1'b0;
      m_sh   <= 8'h00;
    end else if (!m_busy) begin
      if (i_reqValid) begin
        m_busy <= 1'b1;
        m_cnt  <= 1;
        m_kind <= i_reqKind;
        m_addr <= i_reqAddr;
        m_wd   <= i_reqWData;
        m_skip <= m_sv && (i_reqAddr == m_sh);
        m_lat  <= (m_sv && (i_reqAddr == m_sh)) ? 2 : 3;
        m_exp  <= ref_data(i_reqKind, i_reqAddr, i_reqWData);
      end
    end else begin
      if (m_cnt == m_lat) begin
        if (i_rspReady) m_busy <= 1'b0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
      if (!m_skip && m_cnt == 1) begin
        m_sh <= m_addr;
        m_sv <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      logic ae, acc, wr, rv;
      ae  = m_busy && !m_skip && m_cnt == 1;
      acc = m_busy && m_cnt == m_lat - 1;
      wr  = m_kind == 2'd3;
      rv  = m_busy && m_cnt == m_lat;
      chk1("reqReady", o_reqReady, !m_busy);
      chk1("rspValid", o_rspValid, rv);
      chk1("addressEn", o_addressEn, ae);
      chk("address", o_address, ae ? m_addr : m_sh);
      chk1("writeEn", o_writeEn, acc && wr);
      chk1("outEnable", o_outEnable, acc && !wr);
      chk1("we_oe_excl", o_writeEn && o_outEnable, 1'b0);
      if (acc && wr) chk("writeData", o_writeData, m_wd);
      if (acc && !wr) begin
        chk1("rdSel", o_readDataSelect, m_kind != 2'd2);
        chk1("immSel", o_immediateSelect, m_kind == 2'd1);
      end
      if (rv) chk("rspData", o_rspData, m_exp);
    end
  end

  // Observations collected by the directed driver.
  int         lat;
  int         seen_ae;
  logic [7:0] seen_addr;
  logic       seen_we, seen_oe, seen_sel, seen_imm;
  logic [7:0] seen_wd;
  logic [7:0] rdata;

  task automatic observe();
    if (o_addressEn) begin
      seen_ae++;
      seen_addr = o_address;
    end
    if (o_writeEn) begin
      seen_we = 1'b1;
      seen_wd = o_writeData;
    end
    if (o_outEnable) begin
      seen_oe  = 1'b1;
      seen_sel = o_readDataSelect;
      seen_imm = o_immediateSelect;
    end
  endtask

  task automatic issue(input logic [1:0] k, input logic [7:0] a,
                       input logic [7:0] d);
    int n;
    @(negedge clk);
    i_reqValid = 1'b1;
    i_reqKind  = k;
    i_reqAddr  = a;
    i_reqWData = d;
    n = 0;
    while (!o_reqReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk1("accept_timeout", 1'b0, 1'b1);
    @(negedge clk);
    i_reqValid = 1'b0;
    seen_ae = 0;
    seen_we = 1'b0;
    seen_oe = 1'b0;
    seen_sel = 1'b0;
    seen_imm = 1'b0;
    seen_wd = 8'h00;
    seen_addr = 8'h00;
    lat = 1;
    observe();
  endtask

  task automatic txn(input logic [1:0] k, input logic [7:0] a,
                     input logic [7:0] d, input int hold);
    issue(k, a, d);
    while (!o_rspValid && lat < 10) begin
      @(negedge clk);
      lat++;
      observe();
    end
    if (!o_rspValid) chk1("rsp_timeout", 1'b0, 1'b1);
    rdata = o_rspData;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk1("hold_valid", o_rspValid, 1'b1);
      chk("hold_data", o_rspData, rdata);
      chk1("hold_ready", o_reqReady, 1'b0);
    end
    i_rspReady = 1'b1;
    @(negedge clk);
    i_rspReady = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      bus_ram[i] = 8'h00;
      ref_ram[i] = 8'h00;
    end
    i_reset = 1'b1;
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    run_chk = 1'b1;
    chk1("rst_ready", o_reqReady, 1'b1);
    chk1("rst_rspValid", o_rspValid, 1'b0);
    chk("rst_rspData", o_rspData, 8'h00);
    chk("rst_address", o_address, 8'h00);
    chk1("rst_strobes", o_writeEn | o_outEnable | o_addressEn, 1'b0);

    txn(2'd3, 8'h10, 8'hA5, 0);
    chk("wr_lat", 8'(lat), 8'd3);
    chk("wr_ae_cnt", 8'(seen_ae), 8'd1);
    chk("wr_addr", seen_addr, 8'h10);
    chk1("wr_we", seen_we, 1'b1);
    chk("wr_wd", seen_wd, 8'hA5);
    chk("wr_rsp", rdata, 8'hA5);
    chk1("idle_after", o_reqReady, 1'b1);

    txn(2'd2, 8'h10, 8'h00, 0);
    chk("rd_lat", 8'(lat), 8'd2);
    chk("rd_ae_cnt", 8'(seen_ae), 8'd0);
    chk1("rd_oe", seen_oe, 1'b1);
    chk1("rd_sel", seen_sel, 1'b0);
    chk("rd_rsp", rdata, 8'hA5);

    txn(2'd1, 8'h20, 8'h00, 0);
    chk("imm_lat", 8'(lat), 8'd3);
    chk1("imm_sel", seen_sel, 1'b1);
    chk1("imm_imm", seen_imm, 1'b1);
    chk("imm_rsp", rdata, 8'h3C);

    txn(2'd0, 8'h21, 8'h00, 5);
    chk1("ins_sel", seen_sel, 1'b1);
    chk1("ins_imm", seen_imm, 1'b0);
    chk("ins_rsp", rdata, 8'hDE);
    chk1("hold_idle", o_reqReady, 1'b1);

    issue(2'd3, 8'h30, 8'h5A);
    @(negedge clk);
    chk1("abort_we_pre", o_writeEn, 1'b1);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    chk1("abort_we", o_writeEn, 1'b0);
    chk1("abort_rsp", o_rspValid, 1'b0);
    chk1("abort_ready", o_reqReady, 1'b1);
    @(negedge clk);
    chk1("abort_no_rsp", o_rspValid, 1'b0);
    txn(2'd2, 8'h30, 8'h00, 0);
    chk("post_rst_lat", 8'(lat), 8'd3);
    chk("post_rst_ae", 8'(seen_ae), 8'd1);

    for (int t = 0; t < 1000; t++) begin
      logic [1:0] k;
      logic [7:0] a;
      logic [7:0] d;
      int hold;
      k = 2'($urandom_range(0, 3));
      a = 8'($urandom_range(16, 23));
      d = 8'($urandom_range(0, 255));
      hold = $urandom_range(0, 2);
      txn(k, a, d, hold);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    run_chk = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
